// File: rtl/moore_seq_pkg.sv
// Shared constants and elaboration-time helpers for the parametrised Moore sequence detector.
package moore_seq_pkg;

  // Largest supported pattern and the state-index width needed to cover S0..S16.
  localparam int unsigned MaxPatLen = 16;
  localparam int unsigned MaxStW    = 5;

  // Values of the overlap input.
  localparam logic MODE_NONOVERLAP = 1'b0;
  localparam logic MODE_OVERLAP    = 1'b1;

  // Next-state table indexed [state][input bit]; rows beyond PAT_LEN stay zero.
  typedef logic [MaxPatLen:0][1:0][MaxStW-1:0] trans_tbl_t;

  // Bits needed to encode states S0..S_pat_len.
  function automatic int unsigned state_width(input int unsigned pat_len);
    return $clog2(pat_len + 1);
  endfunction

  // KMP automaton: from Sk on bit b, go to the longest pattern prefix that is a suffix of
  // (first k pattern bits, b). Row pat_len gives the overlapping continuation out of S_N.
  // pattern[pat_len-1] is the first bit received.
  function automatic trans_tbl_t build_trans_tbl(input logic [MaxPatLen-1:0] pattern,
                                                 input int pat_len);
    trans_tbl_t     tbl;
    logic [MaxPatLen:0] seq;
    int             len;
    int             best;
    logic           hit;
    tbl = '0;
    for (int k = 0; k <= MaxPatLen; k++) begin
      for (int b = 0; b < 2; b++) begin
        if (k <= pat_len) begin
          // seq[i] holds the i-th received bit
          seq = '0;
          for (int i = 0; i < MaxPatLen; i++) begin
            if (i < k) seq[5'(i)] = pattern[4'(pat_len - 1 - i)];
          end
          seq[5'(k)] = b[0];
          len  = k + 1;
          best = 0;
          for (int j = 1; j <= MaxPatLen; j++) begin
            if (j <= len && j <= pat_len) begin
              hit = 1'b1;
              for (int m = 0; m < MaxPatLen; m++) begin
                if (m < j && seq[5'(len - j + m)] != pattern[4'(pat_len - 1 - m)]) hit = 1'b0;
              end
              if (hit) best = j;
            end
          end
          tbl[5'(k)][1'(b)] = MaxStW'(best);
        end
      end
    end
    return tbl;
  endfunction

endpackage

// File: rtl/moore_seq_detector_param_sat_counter.sv
// Saturating up-counter with synchronous clear; clear takes effect before the increment.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         state_reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] count_d;

  // Clear first, then count, holding at all-ones.
  always_comb begin
    count_d = count;
    if (clr) count_d = '0;
    if (inc && count_d != '1) count_d = count_d + 1'b1;
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!state_reset) count <= '0;
    else              count <= count_d;
  end

endmodule

// File: rtl/moore_seq_detector_param.sv
// Parametrised Moore serial pattern detector with overlap select, stall and match counter.
module moore_seq_detector_param
  import moore_seq_pkg::*;
#(
  parameter int unsigned         PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0]  PATTERN = 4'b1011,
  parameter int unsigned         CNT_W   = 8
) (
  input  logic                               clk,
  input  logic                               state_reset,
  input  logic                               en,
  input  logic                               r,
  input  logic                               overlap,
  input  logic                               clr_count,
  output logic                               out,
  output logic [state_width(PAT_LEN)-1:0]    state_dbg,
  output logic [CNT_W-1:0]                   match_count
);

  localparam int unsigned     StW      = state_width(PAT_LEN);
  localparam trans_tbl_t      TransTbl = build_trans_tbl(MaxPatLen'(PATTERN), PAT_LEN);
  localparam logic [StW-1:0]  StMatch  = StW'(PAT_LEN);

  logic [StW-1:0]    state_q, state_d;
  logic [MaxStW-1:0] tbl_row;
  logic              match_next;

  // State register; reset wins over en.
  always_ff @(posedge clk) begin
    if (!state_reset) state_q <= '0;
    else if (en)      state_q <= state_d;
  end

  // Next state from the elaborated table; non-overlapping exit from S_N reuses the S0 row.
  always_comb begin
    tbl_row = MaxStW'(state_q);
    if (state_q == StMatch && overlap == MODE_NONOVERLAP) tbl_row = '0;
    state_d    = StW'(TransTbl[tbl_row][r]);
    match_next = en && (state_d == StMatch);
  end

  // Moore outputs decoded from the registered state only.
  always_comb begin
    out       = (state_q == StMatch);
    state_dbg = state_q;
  end

  sat_counter #(
    .W (CNT_W)
  ) u_match_cnt (
    .clk         (clk),
    .state_reset (state_reset),
    .inc         (match_next),
    .clr         (clr_count),
    .count       (match_count)
  );

endmodule

// File: tb/tb_moore_seq_detector_param.sv
// Bench for moore_seq_detector_param: directed vector table, hand sequences, random vs model.
module tb_moore_seq_detector_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic state_reset, en, r, overlap, clr_count;

  logic       out_a, out_b, out_c;
  logic [2:0] dbg_a, dbg_c;
  logic [1:0] dbg_b;
  logic [7:0] cnt_a, cnt_b;
  logic [1:0] cnt_c;

  // a: defaults (1011, 8-bit count); b: 111; c: 1011 with 2-bit count
  moore_seq_detector_param dut_a (
    .clk(clk), .state_reset(state_reset), .en(en), .r(r), .overlap(overlap),
    .clr_count(clr_count), .out(out_a), .state_dbg(dbg_a), .match_count(cnt_a)
  );
  moore_seq_detector_param #(.PAT_LEN(3), .PATTERN(3'b111), .CNT_W(8)) dut_b (
    .clk(clk), .state_reset(state_reset), .en(en), .r(r), .overlap(overlap),
    .clr_count(clr_count), .out(out_b), .state_dbg(dbg_b), .match_count(cnt_b)
  );
  moore_seq_detector_param #(.PAT_LEN(4), .PATTERN(4'b1011), .CNT_W(2)) dut_c (
    .clk(clk), .state_reset(state_reset), .en(en), .r(r), .overlap(overlap),
    .clr_count(clr_count), .out(out_c), .state_dbg(dbg_c), .match_count(cnt_c)
  );

  typedef struct {
    int dut;
    bit rst_n, en, r, ov, clr;
    int e_out, e_dbg, e_cnt;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Reference model: bit history since the last restart, matched against the pattern.
  int              m_pat[3] = '{11, 7, 11};
  int              m_n[3]   = '{4, 3, 4};
  int              m_max[3] = '{255, 255, 3};
  longint unsigned m_hist[3];
  int              m_len[3], m_st[3], m_cnt[3];

  function automatic int longest(input int i);
    for (int j = m_n[i]; j >= 1; j--) begin
      if (j <= m_len[i]) begin
        longint unsigned mask;
        mask = (64'd1 << j) - 64'd1;
        if ((m_hist[i] & mask) == (longint'(m_pat[i]) >> (m_n[i] - j))) return j;
      end
    end
    return 0;
  endfunction

  task automatic model_step(input bit rn, input bit e, input bit rr, input bit o, input bit c);
    for (int i = 0; i < 3; i++) begin
      if (!rn) begin
        m_hist[i] = 0; m_len[i] = 0; m_st[i] = 0; m_cnt[i] = 0;
      end else if (e) begin
        if (m_st[i] == m_n[i] && !o) begin
          m_hist[i] = 0; m_len[i] = 0;
        end
        m_hist[i] = (m_hist[i] << 1) | longint'(rr);
        if (m_len[i] < 64) m_len[i]++;
        m_st[i] = longest(i);
        if (c) m_cnt[i] = 0;
        if (m_st[i] == m_n[i] && m_cnt[i] < m_max[i]) m_cnt[i]++;
      end
    end
  endtask

  task automatic drive_edge(input bit rn, input bit e, input bit rr, input bit o, input bit c);
    state_reset = rn; en = e; r = rr; overlap = o; clr_count = c;
    @(posedge clk);
    #1;
    model_step(rn, e, rr, o, c);
  endtask

  task automatic sample(input int d, output int o, output int db, output int c);
    case (d)
      0:       begin o = int'(out_a); db = int'(dbg_a); c = int'(cnt_a); end
      1:       begin o = int'(out_b); db = int'(dbg_b); c = int'(cnt_b); end
      default: begin o = int'(out_c); db = int'(dbg_c); c = int'(cnt_c); end
    endcase
  endtask

  task automatic check(input string name, input int d, input int eo, input int ed, input int ec);
    int o, db, c;
    sample(d, o, db, c);
    n_vec++;
    if (o != eo || db != ed || c != ec) begin
      n_bad++;
      $display("FAIL %s dut%0d: got out=%0d dbg=%0d cnt=%0d, want out=%0d dbg=%0d cnt=%0d",
               name, d, o, db, c, eo, ed, ec);
    end
  endtask

  task automatic add(input int d, input bit rn, input bit e, input bit rr, input bit o,
                     input bit c, input int eo, input int ed, input int ec);
    vec_t v;
    v.dut = d; v.rst_n = rn; v.en = e; v.r = rr; v.ov = o; v.clr = c;
    v.e_out = eo; v.e_dbg = ed; v.e_cnt = ec;
    vecs.push_back(v);
  endtask

  // Shorthand: enabled bit with no clear.
  task automatic bitv(input int d, input bit rr, input bit o, input int eo, input int ed,
                      input int ec);
    add(d, 1'b1, 1'b1, rr, o, 1'b0, eo, ed, ec);
  endtask

  task automatic rstv(input int d);
    add(d, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 0);
  endtask

  initial begin
    state_reset = 1'b0; en = 1'b0; r = 1'b0; overlap = 1'b1; clr_count = 1'b0;

    // basic detect on 0,0,1,0,1,1,1,1,0
    rstv(0);
    bitv(0, 0, 1, 0, 0, 0); bitv(0, 0, 1, 0, 0, 0); bitv(0, 1, 1, 0, 1, 0);
    bitv(0, 0, 1, 0, 2, 0); bitv(0, 1, 1, 0, 3, 0); bitv(0, 1, 1, 1, 4, 1);
    bitv(0, 1, 1, 0, 1, 1); bitv(0, 1, 1, 0, 1, 1); bitv(0, 0, 1, 0, 2, 1);
    // overlapping on 1,0,1,1,0,1,1
    rstv(0);
    bitv(0, 1, 1, 0, 1, 0); bitv(0, 0, 1, 0, 2, 0); bitv(0, 1, 1, 0, 3, 0);
    bitv(0, 1, 1, 1, 4, 1); bitv(0, 0, 1, 0, 2, 1); bitv(0, 1, 1, 0, 3, 1);
    bitv(0, 1, 1, 1, 4, 2);
    // non-overlapping on the same stream
    rstv(0);
    bitv(0, 1, 0, 0, 1, 0); bitv(0, 0, 0, 0, 2, 0); bitv(0, 1, 0, 0, 3, 0);
    bitv(0, 1, 0, 1, 4, 1); bitv(0, 0, 0, 0, 0, 1); bitv(0, 1, 0, 0, 1, 1);
    bitv(0, 1, 0, 0, 1, 1);
    // stall: en low for five edges with r toggling
    rstv(0);
    bitv(0, 1, 1, 0, 1, 0); bitv(0, 0, 1, 0, 2, 0);
    for (int i = 0; i < 5; i++) add(0, 1'b1, 1'b0, 1'(~i[0]), 1'b1, 1'b0, 0, 2, 0);
    bitv(0, 1, 1, 0, 3, 0); bitv(0, 1, 1, 1, 4, 1);
    // re-entrant 111, overlapping then non-overlapping
    rstv(1);
    bitv(1, 1, 1, 0, 1, 0); bitv(1, 1, 1, 0, 2, 0); bitv(1, 1, 1, 1, 3, 1);
    bitv(1, 1, 1, 1, 3, 2); bitv(1, 1, 1, 1, 3, 3);
    rstv(1);
    bitv(1, 1, 0, 0, 1, 0); bitv(1, 1, 0, 0, 2, 0); bitv(1, 1, 0, 1, 3, 1);
    bitv(1, 1, 0, 0, 1, 1); bitv(1, 1, 0, 0, 2, 1);
    // reset mid-pattern, with en low and clr high to show reset dominates
    rstv(0);
    bitv(0, 1, 1, 0, 1, 0); bitv(0, 0, 1, 0, 2, 0); bitv(0, 1, 1, 0, 3, 0);
    add(0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 0, 0, 0);
    bitv(0, 1, 1, 0, 1, 0);

    foreach (vecs[i]) begin
      drive_edge(vecs[i].rst_n, vecs[i].en, vecs[i].r, vecs[i].ov, vecs[i].clr);
      check($sformatf("vec%0d", i), vecs[i].dut, vecs[i].e_out, vecs[i].e_dbg, vecs[i].e_cnt);
    end

    // saturation on the 2-bit counter: five non-overlapping 1011 matches
    drive_edge(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("sat_reset", 2, 0, 0, 0);
    for (int g = 0; g < 5; g++) begin
      drive_edge(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      drive_edge(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      drive_edge(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      drive_edge(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      check($sformatf("sat_match%0d", g), 2, 1, 4, (g < 3) ? g + 1 : 3);
    end
    // clear on the same edge as a match gives one
    drive_edge(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    drive_edge(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    drive_edge(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("pre_clr", 2, 0, 3, 3);
    drive_edge(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    check("clr_with_match", 2, 1, 4, 1);
    drive_edge(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    check("clr_no_match", 2, 0, 0, 0);

    // random stream on all three instances against the model
    drive_edge(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    begin
      bit ov_r;
      ov_r = 1'b1;
      for (int t = 0; t < 3000; t++) begin
        bit rn, e, rr, c;
        rn = ($urandom_range(0, 149) != 0);
        e  = ($urandom_range(0, 3) != 0);
        rr = 1'($urandom);
        if ($urandom_range(0, 7) == 0) ov_r = ~ov_r;
        c  = e && ($urandom_range(0, 15) == 0);
        drive_edge(rn, e, rr, ov_r, c);
        for (int i = 0; i < 3; i++) begin
          check($sformatf("rand%0d", t), i, (m_st[i] == m_n[i]) ? 1 : 0, m_st[i], m_cnt[i]);
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
